// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam logic [3:0]  BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0]  BCD_ADJ_ADD    = 4'd3;

  // True when DIGITS decimal digits can hold every WIDTH-bit unsigned value.
  function automatic bit bcd_fits(input int unsigned width, input int unsigned digits);
    logic [127:0] pow10;
    logic [127:0] max_val;
    if (digits >= 38) return 1'b1;
    if (width >= 120) return 1'b0;
    pow10 = 128'd1;
    for (int unsigned i = 0; i < digits; i++) pow10 = pow10 * 128'd10;
    max_val = (128'd1 << width) - 128'd1;
    return pow10 > max_val;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  // Add-3 correction so the following left shift carries into the next decade.
  always_comb begin
    digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + BCD_ADJ_ADD : digit_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (one bit per clock) with leading-zero blank mask.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DIGITS   = 5,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [WIDTH-1:0]              bin_i,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          valid_o,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_o,
  output logic [DIGITS-1:0]             blank_o
);

  localparam int unsigned AccW = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  if (!bcd_fits(WIDTH, DIGITS)) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS too small to represent every WIDTH-bit value");
  end

  // Digit k is dark when k > 0 and every digit from k upwards is zero.
  function automatic logic [DIGITS-1:0] blank_of(input logic [AccW-1:0] acc);
    logic [DIGITS-1:0] mask;
    logic              zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (acc[BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
      mask[k]    = zero_above;
    end
    return LZ_BLANK ? mask : '0;
  endfunction

  localparam logic [DIGITS-1:0] BlankRst = blank_of('0);

  bcd_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [AccW-1:0]   acc_q, acc_d;
  logic [AccW-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0] blank_q, blank_d;
  logic              valid_q, valid_d;

  logic [AccW-1:0]   acc_adj;
  logic [AccW-1:0]   acc_shift;
  logic              unused_acc_msb;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (acc_q[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .digit_o (acc_adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  // The top accumulator bit is always zero after adjust when DIGITS is sized correctly.
  assign unused_acc_msb = acc_adj[AccW-1];
  assign acc_shift      = {acc_adj[AccW-2:0], sr_q[WIDTH-1]};

  // Next-state: accept in idle, adjust-and-shift in SHIFT, publish on the last bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sr_d    = bin_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d = acc_shift;
        sr_d  = {sr_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          bcd_d   = acc_shift;
          blank_d = blank_of(acc_shift);
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset aborts any conversion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      blank_q <= BlankRst;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = (state_q == StShift);
  assign valid_o = valid_q;
  assign bcd_o   = bcd_q;
  assign blank_o = blank_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
module tb_bin_to_bcd_seq;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_a, start_b;
  logic [W-1:0]     bin;
  logic             busy_a, valid_a, busy_b, valid_b;
  logic [4*D-1:0]   bcd_a, bcd_b;
  logic [D-1:0]     blank_a, blank_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .LZ_BLANK(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bin_i   (bin),
    .start_i (start_a),
    .busy_o  (busy_a),
    .valid_o (valid_a),
    .bcd_o   (bcd_a),
    .blank_o (blank_a)
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D), .LZ_BLANK(1'b0)) dut_nb (
    .clk_i   (clk),
    .rst_i   (rst),
    .bin_i   (bin),
    .start_i (start_b),
    .busy_o  (busy_b),
    .valid_o (valid_b),
    .bcd_o   (bcd_b),
    .blank_o (blank_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned    x;
    r = '0;
    x = v;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_blank(input int unsigned v, input bit lz);
    logic [D-1:0] m;
    int unsigned  p;
    m = '0;
    p = 1;
    for (int k = 1; k < D; k++) begin
      p    = p * 10;
      m[k] = lz && (v < p);
    end
    return m;
  endfunction

  // Start one conversion on instance sel (0: blanking, 1: no blanking) and check it.
  task automatic convert(input logic [W-1:0] v, input bit sel);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bin = v;
    if (sel) start_b = 1'b1;
    else     start_a = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    start_b  = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && lat <= 40) begin
      if (sel ? valid_b : valid_a) begin
        seen = 1'b1;
      end else begin
        if (sel ? busy_b : busy_a) busy_cnt++;
        lat++;
        @(negedge clk);
      end
    end
    check_eq("valid_seen", seen, 1);
    if (seen) begin
      check_eq("latency", lat, W);
      check_eq("busy_cycles", busy_cnt, W);
      check_eq("busy_in_valid", sel ? busy_b : busy_a, 0);
      check_eq("bcd", sel ? bcd_b : bcd_a, ref_bcd(v));
      check_eq("blank", sel ? blank_b : blank_a, ref_blank(v, !sel));
      @(negedge clk);
      check_eq("valid_pulse", sel ? valid_b : valid_a, 0);
      check_eq("bcd_hold", sel ? bcd_b : bcd_a, ref_bcd(v));
    end
  endtask

  initial begin
    int lat;
    int vcnt;
    logic [W-1:0] v;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bin     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_bcd", bcd_a, 0);
    check_eq("rst_blank", blank_a, 5'b11110);
    check_eq("rst_blank_nb", blank_b, 0);
    rst = 1'b0;

    // Directed values from the plan and decade boundaries.
    convert(16'd0, 0);
    convert(16'd65535, 0);
    convert(16'd1234, 0);
    convert(16'd9, 0);
    convert(16'd10, 0);
    convert(16'd99, 0);
    convert(16'd100, 0);
    convert(16'd9999, 0);
    convert(16'd10000, 0);
    convert(16'd7, 1);
    convert(16'd0, 1);

    // start held high while busy; bin change ignored; 999 accepted in the valid cycle.
    @(negedge clk);
    bin     = 16'd100;
    start_a = 1'b1;
    @(negedge clk);
    bin = 16'd999;
    lat = 0;
    while (!valid_a && lat <= 40) begin
      lat++;
      @(negedge clk);
    end
    check_eq("b2b_first_lat", lat, W);
    check_eq("b2b_first_bcd", bcd_a, 20'h00100);
    check_eq("b2b_first_blank", blank_a, 5'b11000);
    @(negedge clk);
    start_a = 1'b0;
    check_eq("b2b_accept_busy", busy_a, 1);
    lat = 1;
    while (!valid_a && lat <= 40) begin
      lat++;
      @(negedge clk);
    end
    check_eq("b2b_second_gap", lat, W + 1);
    check_eq("b2b_second_bcd", bcd_a, 20'h00999);
    check_eq("b2b_second_blank", blank_a, 5'b11000);
    @(negedge clk);
    check_eq("b2b_no_third", busy_a, 0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bin     = 16'd4321;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", busy_a, 0);
    check_eq("abort_valid", valid_a, 0);
    check_eq("abort_bcd", bcd_a, 0);
    check_eq("abort_blank", blank_a, 5'b11110);
    vcnt = 0;
    repeat (30) begin
      if (valid_a) vcnt++;
      @(negedge clk);
    end
    check_eq("abort_no_valid", vcnt, 0);
    convert(16'd4321, 0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst     = 1'b1;
    start_a = 1'b1;
    bin     = 16'd555;
    @(negedge clk);
    rst     = 1'b0;
    start_a = 1'b0;
    check_eq("rst_wins_busy", busy_a, 0);
    check_eq("rst_wins_bcd", bcd_a, 0);

    // Random sweep.
    for (int i = 0; i < 1500; i++) begin
      v = W'($urandom);
      if (i % 4 == 1) v = W'($urandom_range(0, 120));
      convert(v, (i % 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
